irq_flag_unit: RTL
==================

Name: irq_flag_unit

Overview:
Upstream companion of the SM83 core. Collects peripheral interrupt request lines into the IF register at 0xFF0F and drives CPU_IRQ_TRIG into the core. Consumes CPU_IRQ_ACK from the core to clear serviced requests. Also owns the boot-ROM disable latch at 0xFF50, and generates the core's MMIO_REQ and IPL_REQ inputs from the address bus.

Parameters:
NUM_IRQ, 5, number of implemented interrupt sources (IF bits [NUM_IRQ-1:0]).
IF_ADDR, 16'hFF0F, address of the IF register.
BOOT_ADDR, 16'hFF50, address of the boot-ROM disable register.

Ports:
CLK  input  1  single system clock; all state updates on rising edge.
nRESET  input  1  asynchronous, active-low reset.
A  input  16  CPU address bus.
DIN  input  8  CPU write data.
RD  input  1  CPU read strobe, active high.
WR  input  1  CPU write strobe, active high.
DOUT  output  8  read data for owned registers.
DOUT_ENA  output  1  high when DOUT must drive the data bus.
IRQ_SRC  input  NUM_IRQ  peripheral request levels, synchronous to CLK; bit 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
CPU_IRQ_ACK  input  8  per-bit acknowledge from the core; bits above NUM_IRQ-1 ignored.
CPU_IRQ_TRIG  output  8  pending requests to the core.
MMIO_REQ  output  1  high when A is 0xFExx or 0xFFxx.
IPL_REQ  output  1  high when A is 0x00xx and the boot ROM is still mapped.
BOOT_OFF  output  1  sticky boot-ROM-disabled flag.

Behaviour:
- State: if_q[NUM_IRQ-1:0], src_q[NUM_IRQ-1:0] (previous IRQ_SRC), wr_q (previous WR), boot_off_q.
- Reset values (asynchronous, take effect immediately while nRESET is low): if_q=0, boot_off_q=0, src_q=all ones, wr_q=1.
  - src_q=all ones means sources already high at reset release do not fire.
  - wr_q=1 means a WR held high across reset release causes no write.
- Outputs during reset: CPU_IRQ_TRIG=0, BOOT_OFF=0. DOUT/DOUT_ENA/MMIO_REQ/IPL_REQ follow the combinational rules below.
- Edge detect: set[i] = IRQ_SRC[i] & ~src_q[i]. A source held high sets the bit once only.
- Write strobe: wstb = WR & ~wr_q. Each WR pulse commits exactly one write, on the first clock edge WR is seen high.
- Per-bit IF next state, in priority order:
  - set → 1
  - else CPU_IRQ_ACK[i] → 0
  - else wstb & A==IF_ADDR → DIN[i]
  - else hold
  - A new request edge coincident with an ack or a write always survives.
- Latency: IRQ_SRC rises before edge N → CPU_IRQ_TRIG bit high after edge N (one cycle). ACK high at edge N → bit low after edge N.
- CPU_IRQ_TRIG = {zeros, if_q}; bits [7:NUM_IRQ] are always 0.
- BOOT_OFF latch:
  - wstb & A==BOOT_ADDR & DIN[0]=1 sets boot_off_q.
  - Writes with DIN[0]=0 are ignored; only nRESET clears it.
  - BOOT_OFF = boot_off_q.
- Reads (combinational):
  - DOUT_ENA = RD & (A==IF_ADDR | A==BOOT_ADDR).
  - IF read: DOUT = {ones[7:NUM_IRQ], if_q}.
  - BOOT read: DOUT = {7'b1111111, boot_off_q}.
  - Otherwise DOUT = 8'hFF.
  - Reads have no side effects.
- MMIO_REQ = (A[15:9]==7'b1111111).
- IPL_REQ = ~boot_off_q & (A[15:8]==8'h00).
- Simultaneous RD and WR to the same register: the read returns the pre-write value; the write commits at the edge.

Decomposition:
- Shared package holds: IF_ADDR_DEF, BOOT_ADDR_DEF, IRQ bit indices (IRQ_VBLANK=0, IRQ_STAT=1, IRQ_TIMER=2, IRQ_SERIAL=3, IRQ_JOYPAD=4), NUM_IRQ_DEF.
- One natural sub-module, irq_flag_bit. It contains:
  - the src_q flop and edge detector,
  - the if_q flop with the set > ack > write priority,
  - an async active-low reset.
- irq_flag_unit instantiates NUM_IRQ copies and adds address decode, the write-strobe edge detector, the boot latch and the read mux.

Test Plan:
1. Reset release with IRQ_SRC=5'b00001 held high → CPU_IRQ_TRIG stays 8'h00. Drop, then raise IRQ_SRC[0] → TRIG=8'h01 one cycle after the rise. Hold high for 10 cycles, ACK bit 0 for one cycle → TRIG=8'h00 and stays 0.
2. Write 8'h1F to 0xFF0F (WR high 3 cycles) → exactly one commit, TRIG=8'h1F. Read 0xFF0F → DOUT=8'hFF, DOUT_ENA=1. ACK=8'h04 → read returns 8'hFB.
3. Same edge: IRQ_SRC[2] rises, CPU_IRQ_ACK[2]=1, and a write of 8'h00 to 0xFF0F → TRIG[2]=1 afterwards; the other bits become 0 from the write.
4. A=0x0042 → IPL_REQ=1, MMIO_REQ=0. Write 8'h00 to 0xFF50 → IPL_REQ stays 1. Write 8'h01 → IPL_REQ=0, BOOT_OFF=1, read 0xFF50=8'hFF. Write 8'h00 again → BOOT_OFF stays 1.
5. Address sweep 0xFDFF/0xFE00/0xFF80/0xFFFF → MMIO_REQ=0/1/1/1. RD at 0xFF10 → DOUT_ENA=0, DOUT=8'hFF.
6. Assert nRESET low mid-operation with TRIG=8'h15 and BOOT_OFF=1 → both are 0 before the next CLK edge. After release, IRQ_SRC held at 5'b11111 produces no TRIG until a fresh rising edge.

Source files
------------

// File: rtl/irq_flag_unit_pkg.sv
// Shared constants for the interrupt-flag unit: register addresses, IRQ bit map
// and address-window helpers used by the decode logic.
package irq_flag_unit_pkg;

    localparam int          NUM_IRQ_DEF   = 5;
    localparam logic [15:0] IF_ADDR_DEF   = 16'hFF0F;
    localparam logic [15:0] BOOT_ADDR_DEF = 16'hFF50;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    // 0xFE00-0xFFFF: OAM, IO registers and HRAM all route through the MMIO path
    function automatic logic addr_is_mmio(input logic [15:0] addr);
        return addr[15:9] == 7'b1111111;
    endfunction

    // First page of the map, shadowed by the boot ROM until it is disabled
    function automatic logic addr_is_ipl(input logic [15:0] addr);
        return addr[15:8] == 8'h00;
    endfunction

endpackage

// File: rtl/irq_flag_unit_if.sv
// CPU-side bus, peripheral request lines and core interrupt handshake of the flag unit.
// master = CPU/peripheral side, slave = irq_flag_unit.
interface irq_flag_unit_if #(
    parameter int NUM_IRQ = 5
);
    logic [15:0]        A;
    logic [7:0]         DIN;
    logic               RD;
    logic               WR;
    logic [7:0]         DOUT;
    logic               DOUT_ENA;
    logic [NUM_IRQ-1:0] IRQ_SRC;
    logic [7:0]         CPU_IRQ_ACK;
    logic [7:0]         CPU_IRQ_TRIG;
    logic               MMIO_REQ;
    logic               IPL_REQ;
    logic               BOOT_OFF;

    modport master (
        output A, DIN, RD, WR, IRQ_SRC, CPU_IRQ_ACK,
        input  DOUT, DOUT_ENA, CPU_IRQ_TRIG, MMIO_REQ, IPL_REQ, BOOT_OFF
    );

    modport slave (
        input  A, DIN, RD, WR, IRQ_SRC, CPU_IRQ_ACK,
        output DOUT, DOUT_ENA, CPU_IRQ_TRIG, MMIO_REQ, IPL_REQ, BOOT_OFF
    );

endinterface

// File: rtl/irq_flag_unit_bit.sv
// One IF bit: rising-edge request capture with set > ack > write priority.
// Latency: source edge or ack visible one cycle later; no backpressure.
module irq_flag_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic i_src,
    input  logic i_ack,
    input  logic i_wr_en,
    input  logic i_wr_dat,
    output logic o_flag
);

    logic r_src;
    logic r_flag;
    logic w_set;

    assign w_set  = i_src & ~r_src;
    assign o_flag = r_flag;

    // r_src resets high so a line already asserted at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src  <= 1'b1;
            r_flag <= 1'b0;
        end else begin
            r_src <= i_src;
            if (w_set) begin
                r_flag <= 1'b1;
            end else if (i_ack) begin
                r_flag <= 1'b0;
            end else if (i_wr_en) begin
                r_flag <= i_wr_dat;
            end
        end
    end

endmodule

// File: rtl/irq_flag_unit.sv
// IF register (0xFF0F), boot-ROM disable latch (0xFF50) and MMIO/IPL decode for the core.
// Latency: writes/requests/acks take effect after one edge, reads are combinational; no backpressure.
module irq_flag_unit
    import irq_flag_unit_pkg::*;
#(
    parameter int          NUM_IRQ   = NUM_IRQ_DEF,
    parameter logic [15:0] IF_ADDR   = IF_ADDR_DEF,
    parameter logic [15:0] BOOT_ADDR = BOOT_ADDR_DEF
) (
    input  logic            CLK,
    input  logic            nRESET,
    irq_flag_unit_if.slave  bus
);

    logic               r_wr;
    logic               r_boot_off;
    logic               w_wstb;
    logic               w_if_hit;
    logic               w_boot_hit;
    logic               w_if_wr;
    logic [NUM_IRQ-1:0] w_if;
    logic [7:0]         w_trig;
    logic [7:0]         w_dout;
    logic               w_unused;

    assign w_if_hit   = (bus.A == IF_ADDR);
    assign w_boot_hit = (bus.A == BOOT_ADDR);

    // A held WR commits once, on its first edge; r_wr resets high so a WR
    // already asserted at reset release does not count as a new strobe
    assign w_wstb  = bus.WR & ~r_wr;
    assign w_if_wr = w_wstb & w_if_hit;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_wr       <= 1'b1;
            r_boot_off <= 1'b0;
        end else begin
            r_wr <= bus.WR;
            if (w_wstb & w_boot_hit & bus.DIN[0]) begin
                r_boot_off <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_bit
        irq_flag_bit u_bit (
            .clk      (CLK),
            .rst_n    (nRESET),
            .i_src    (bus.IRQ_SRC[i]),
            .i_ack    (bus.CPU_IRQ_ACK[i]),
            .i_wr_en  (w_if_wr),
            .i_wr_dat (bus.DIN[i]),
            .o_flag   (w_if[i])
        );
    end

    always_comb begin
        w_trig              = 8'h00;
        w_trig[NUM_IRQ-1:0] = w_if;
    end

    // Unimplemented IF bits read back as 1, matching the original hardware
    always_comb begin
        w_dout = 8'hFF;
        if (bus.RD & w_if_hit) begin
            w_dout[NUM_IRQ-1:0] = w_if;
        end else if (bus.RD & w_boot_hit) begin
            w_dout[0] = r_boot_off;
        end
    end

    assign bus.CPU_IRQ_TRIG = w_trig;
    assign bus.DOUT         = w_dout;
    assign bus.DOUT_ENA     = bus.RD & (w_if_hit | w_boot_hit);
    assign bus.BOOT_OFF     = r_boot_off;
    assign bus.MMIO_REQ     = addr_is_mmio(bus.A);
    assign bus.IPL_REQ      = ~r_boot_off & addr_is_ipl(bus.A);

    // Upper ack and data bits have no destination when NUM_IRQ < 8
    assign w_unused = &{1'b0, bus.CPU_IRQ_ACK, bus.DIN};

endmodule
